// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDU_Op,
   input  logic [31:0] E_RS,
   input  logic [31:0] E_RT,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_MDU_Out
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   logic [3:0]  r_count;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [3:0]  r_op;

   state_t      w_state;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;
   logic [31:0] w_a_nxt;
   logic [31:0] w_b_nxt;
   logic [3:0]  w_op_nxt;
   logic        w_is_mul;
   logic        w_is_div;
   logic [63:0] w_hilo;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_db;
   logic [31:0] w_quo_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_quo_u;
   logic [31:0] w_rem_u;
   logic [63:0] w_res;

   assign w_state = (r_count != 4'd0) ? S_BUSY : S_IDLE;
   assign E_Busy  = (r_count != 4'd0);

   always_comb begin
      w_is_mul = 1'b0;
      w_is_div = 1'b0;
      unique case (E_MDU_Op)
         OP_MULT, OP_MULTU: w_is_mul = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU,
         OP_MSUB, OP_MSUBU: w_is_mul = 1'b1;
`endif
         OP_DIV, OP_DIVU:   w_is_div = 1'b1;
         default: ;
      endcase
   end

   assign E_Start = (w_is_mul | w_is_div) & ~E_Busy;

   assign E_MDU_Out = (E_MDU_Op == OP_MFHI) ? r_hi :
                      (E_MDU_Op == OP_MFLO) ? r_lo : 32'd0;

   // Arithmetic works only on latched operands, never on live E_RS/E_RT
   assign w_hilo   = {r_hi, r_lo};
   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
   assign w_db     = (r_b == 32'd0) ? 32'd1 : r_b;
   assign w_quo_s  = $signed(r_a) / $signed(w_db);
   assign w_rem_s  = $signed(r_a) % $signed(w_db);
   assign w_quo_u  = r_a / w_db;
   assign w_rem_u  = r_a % w_db;

   always_comb begin
      w_res = w_hilo;
      unique case (r_op)
         OP_MULT:  w_res = w_prod_s;
         OP_MULTU: w_res = w_prod_u;
         OP_DIV:   if (r_b != 32'd0) w_res = {w_rem_s, w_quo_s};
         OP_DIVU:  if (r_b != 32'd0) w_res = {w_rem_u, w_quo_u};
`ifdef MDU_MADD_EN
         OP_MADD:  w_res = w_hilo + w_prod_s;
         OP_MADDU: w_res = w_hilo + w_prod_u;
         OP_MSUB:  w_res = w_hilo - w_prod_s;
         OP_MSUBU: w_res = w_hilo - w_prod_u;
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_cnt_nxt = r_count;
      w_hi_nxt  = r_hi;
      w_lo_nxt  = r_lo;
      w_a_nxt   = r_a;
      w_b_nxt   = r_b;
      w_op_nxt  = r_op;
      unique case (w_state)
         S_IDLE: begin
            if (E_Start) begin
               w_a_nxt   = E_RS;
               w_b_nxt   = E_RT;
               w_op_nxt  = E_MDU_Op;
               w_cnt_nxt = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (E_MDU_Op == OP_MTHI) begin
               w_hi_nxt = E_RS;
            end else if (E_MDU_Op == OP_MTLO) begin
               w_lo_nxt = E_RS;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_count - 4'd1;
            if (r_count == 4'd1) begin
               w_hi_nxt = w_res[63:32];
               w_lo_nxt = w_res[31:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 4'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 4'd0;
      end else begin
         r_count <= w_cnt_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
      end
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and serves mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Drives E_Start/E_Busy back to the hazard/stall unit, which stalls any HI/LO-using instruction held in D while (E_Start | E_Busy).
- It is the busy-reporting responder to the stall unit's request logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family), legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu, legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- E_MDU_Op  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 9-12 are valid only with MDU_MADD_EN.
- E_RS  input  32  forwarded rs operand.
- E_RT  input  32  forwarded rt operand.
- E_Start  output  1  combinational; 1 when E_MDU_Op is a multi-cycle op (1-4, or 9-12 when enabled) and E_Busy==0.
- E_Busy  output  1  registered; high while an operation is in flight.
- E_MDU_Out  output  32  HI when op==MFHI, LO when op==MFLO, else 0; combinational from the HI/LO registers.

Behaviour:
- Reset (async, any time including mid-operation): HI=0, LO=0, count=0, E_Busy=0, latched operands and op cleared. The in-flight result is discarded.
- State is a 4-bit down-counter `count`; E_Busy = (count != 0). Two states: IDLE (count==0) and BUSY (count!=0).
- IDLE + E_Start at edge:
  - Latch E_RS, E_RT and the op.
  - Load count = MULT_CYCLES for mult-class ops, DIV_CYCLES for div-class ops.
  - E_Busy rises the cycle after the start cycle and stays high for exactly N cycles.
- BUSY, count>1: decrement.
- BUSY, count==1: write the latched result to HI/LO, then count→0.
  - The new HI/LO are visible to MFHI/MFLO in the first cycle E_Busy==0.
- Total latency from the start edge to the HI/LO update edge = N cycles.
- MULT: {HI,LO} = signed 32x32 → 64-bit product.
- MULTU: {HI,LO} = unsigned 32x32 → 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. Example: -7/2 → LO = -3, HI = -1.
- DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero: the operation still runs the full DIV_CYCLES busy period, and HI/LO are left unchanged.
- MTHI/MTLO: while IDLE, write E_RS into HI or LO at the edge; no busy period.
- Ops arriving while BUSY (any op, including MTHI/MTLO and new starts) are ignored. The hazard unit guarantees none arrive; the ignoring is defensive.
- E_Start is never asserted while E_Busy==1.
- MFHI/MFLO while BUSY return the old HI/LO. The hazard unit stalls these ops, so this case is not reached in normal flow.
- A nop bubble inserted by D_E_clear presents op NONE, so no spurious start occurs.
- Results are computed from the latched operands, so changes on E_RS/E_RT after the start cycle have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 9-12 are enabled and use MULT_CYCLES.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - MSUBU: {HI,LO} -= unsigned product.
  - All four are 64-bit arithmetic wrapping mod 2^64, using the HI/LO values sampled at the start edge.
- Undefined: ops 9-12 are treated as NONE; E_Start stays 0 and there is no state change.

Test Plan:
- Reset mid-divide: reset asserted with count==4 → E_Busy=0, HI=LO=0 immediately, with no clock edge required.
- MULT with E_RS=0xFFFFFFFE (-2), E_RT=3 → E_Start=1 in the start cycle; E_Busy high for exactly 5 cycles; afterwards MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA.
- DIV with E_RS=0xFFFFFFF9 (-7), E_RT=2 → busy for 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
- Prior MTHI 0x1234, MTLO 0x5678, then DIV by E_RT=0 → full 10-cycle busy period; HI=0x1234 and LO=0x5678 unchanged.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, with MTLO 0xAA and a second MULT presented during busy → both presented ops are ignored; final HI=0xFFFFFFFE, LO=0x00000001; E_Start stays 0 while busy.
- With MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, then MADDU 1*1 → HI=1, LO=0 after 5 cycles. With the macro undefined, the same op leaves HI/LO unchanged and E_Start=0.
